// File: rtl/cpu_types_pkg.sv
//------------------------------------------------------------------------------
// Module      : cpu_types_pkg
// Description : Shared CPU word/register types and writeback state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    localparam regbits_t LINK_REG = 5'd31;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        COMMIT    = 2'd2
    } wb_state_t;

endpackage : cpu_types_pkg

`default_nettype wire

// File: rtl/regfile_writeback.sv
//------------------------------------------------------------------------------
// Module      : regfile_writeback
// Description : Decides when/where/what the register file writes; holds loads
//               pending until the data cache returns and stalls fetch meanwhile.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_writeback
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dhit,
    input  word_t    Instruction,
    input  logic     RegWrite,
    input  logic     RegDst,
    input  logic     JAL,
    input  logic     MemToReg,
    input  logic     dREN,
    input  word_t    ALUResult,
    input  word_t    PC4,
    input  word_t    dload,
    output logic     WEN,
    output regbits_t wsel,
    output word_t    wdat,
    output word_t    lastInstruction,
    output logic     stall,
    output regbits_t pend_sel
);

    wb_state_t r_state;
    logic      r_wen;
    regbits_t  r_wsel;
    word_t     r_wdat;
    word_t     r_last_instr;
    regbits_t  r_pend_sel;

    regbits_t  w_dest;
    logic      w_accept;
    logic      w_write_valid;
    logic      w_is_load;

    always_comb begin
        w_dest = Instruction[20:16];
        if (JAL) begin
            w_dest = LINK_REG;
        end else if (RegDst) begin
            w_dest = Instruction[15:11];
        end
    end

    // WAIT_DATA owns the pipeline until the cache answers; issues there are ignored.
    assign w_accept      = ihit && (r_state != WAIT_DATA);
    assign w_write_valid = RegWrite && (w_dest != '0);
    assign w_is_load     = MemToReg && dREN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_wen        <= 1'b0;
            r_wsel       <= '0;
            r_wdat       <= '0;
            r_last_instr <= '0;
            r_pend_sel   <= '0;
        end else begin
            case (r_state)
                WAIT_DATA: begin
                    if (dhit) begin
                        r_wsel     <= r_pend_sel;
                        r_wdat     <= dload;
                        r_pend_sel <= '0;
                        r_wen      <= 1'b1;
                        r_state    <= COMMIT;
                    end
                end
                default: begin
                    r_wen   <= 1'b0;
                    r_state <= IDLE;
                    if (w_accept) begin
                        r_last_instr <= Instruction;
                        if (w_write_valid) begin
                            if (w_is_load && !dhit) begin
                                r_pend_sel <= w_dest;
                                r_state    <= WAIT_DATA;
                            end else begin
                                r_wsel  <= w_dest;
                                r_wen   <= 1'b1;
                                r_state <= COMMIT;
                                if (w_is_load) begin
                                    r_wdat <= dload;
                                end else begin
                                    r_wdat <= JAL ? PC4 : ALUResult;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign WEN             = r_wen;
    assign wsel            = r_wsel;
    assign wdat            = r_wdat;
    assign lastInstruction = r_last_instr;
    assign pend_sel        = r_pend_sel;
    assign stall           = (r_state == WAIT_DATA);

endmodule : regfile_writeback

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
//------------------------------------------------------------------------------
// Module      : tb_regfile_writeback
// Description : Directed self-checking bench for regfile_writeback.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_writeback;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     nRST = 1'b0;
    logic     ihit = 1'b0;
    logic     dhit = 1'b0;
    word_t    Instruction = '0;
    logic     RegWrite = 1'b0;
    logic     RegDst = 1'b0;
    logic     JAL = 1'b0;
    logic     MemToReg = 1'b0;
    logic     dREN = 1'b0;
    word_t    ALUResult = '0;
    word_t    PC4 = '0;
    word_t    dload = '0;
    logic     WEN;
    regbits_t wsel;
    word_t    wdat;
    word_t    lastInstruction;
    logic     stall;
    regbits_t pend_sel;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_writeback dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .Instruction(Instruction), .RegWrite(RegWrite), .RegDst(RegDst),
        .JAL(JAL), .MemToReg(MemToReg), .dREN(dREN), .ALUResult(ALUResult),
        .PC4(PC4), .dload(dload), .WEN(WEN), .wsel(wsel), .wdat(wdat),
        .lastInstruction(lastInstruction), .stall(stall), .pend_sel(pend_sel)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic word_t enc(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        enc = {6'h00, rs, rt, rd, 11'h020};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_ctrl();
        ihit = 0; dhit = 0; RegWrite = 0; RegDst = 0; JAL = 0; MemToReg = 0; dREN = 0;
    endtask

    task automatic test_reset();
        nRST = 0;
        #3;
        n_cmp++; if (WEN !== 1'b0)   begin n_bad++; $display("FAIL reset_wen got %0b want 0", WEN); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall); end
        n_cmp++; if (wsel !== 5'd0)  begin n_bad++; $display("FAIL reset_wsel got %0d want 0", wsel); end
        n_cmp++; if (wdat !== 32'h0) begin n_bad++; $display("FAIL reset_wdat got %h want 0", wdat); end
        n_cmp++; if (lastInstruction !== 32'h0) begin n_bad++; $display("FAIL reset_last got %h want 0", lastInstruction); end
        n_cmp++; if (pend_sel !== 5'd0) begin n_bad++; $display("FAIL reset_pend got %0d want 0", pend_sel); end
        @(negedge CLK);
        nRST = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (WEN !== 1'b0 || stall !== 1'b0) begin
                n_bad++; $display("FAIL idle_cycle%0d got wen=%0b stall=%0b want 0/0", i, WEN, stall);
            end
        end
    endtask

    task automatic test_rtype();
        clr_ctrl();
        Instruction = enc(5'd2, 5'd3, 5'd5); RegWrite = 1; RegDst = 1; ALUResult = 32'h0000_00AA; ihit = 1;
        tick();
        ihit = 0;
        n_cmp++; if (WEN !== 1'b1 || wsel !== 5'd5 || wdat !== 32'hAA) begin
            n_bad++; $display("FAIL rtype_write got wen=%0b wsel=%0d wdat=%h want 1/5/000000aa", WEN, wsel, wdat);
        end
        n_cmp++; if (lastInstruction !== enc(5'd2, 5'd3, 5'd5)) begin
            n_bad++; $display("FAIL rtype_last got %h want %h", lastInstruction, enc(5'd2, 5'd3, 5'd5));
        end
        tick();
        n_cmp++; if (WEN !== 1'b0 || wsel !== 5'd5 || wdat !== 32'hAA) begin
            n_bad++; $display("FAIL rtype_hold got wen=%0b wsel=%0d wdat=%h want 0/5/000000aa", WEN, wsel, wdat);
        end
    endtask

    task automatic test_jal();
        clr_ctrl();
        Instruction = 32'h0C00_0041; RegWrite = 1; JAL = 1; PC4 = 32'h0000_0104; ALUResult = 32'h5555_5555; ihit = 1;
        tick();
        ihit = 0;
        n_cmp++; if (WEN !== 1'b1 || wsel !== 5'd31 || wdat !== 32'h104) begin
            n_bad++; $display("FAIL jal_write got wen=%0b wsel=%0d wdat=%h want 1/31/00000104", WEN, wsel, wdat);
        end
        tick();
        clr_ctrl();
        Instruction = enc(5'd1, 5'd2, 5'd0); RegWrite = 1; RegDst = 1; ALUResult = 32'h1234_5678; ihit = 1;
        tick();
        ihit = 0;
        n_cmp++; if (WEN !== 1'b0 || wsel !== 5'd31 || wdat !== 32'h104) begin
            n_bad++; $display("FAIL r0_drop got wen=%0b wsel=%0d wdat=%h want 0/31/00000104", WEN, wsel, wdat);
        end
        n_cmp++; if (lastInstruction !== enc(5'd1, 5'd2, 5'd0)) begin
            n_bad++; $display("FAIL r0_last got %h want %h", lastInstruction, enc(5'd1, 5'd2, 5'd0));
        end
        tick();
        n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL r0_after got wen=%0b want 0", WEN); end
    endtask

    task automatic test_load_late();
        word_t ld_instr;
        ld_instr = {6'h23, 5'd4, 5'd8, 16'h0010};
        clr_ctrl();
        Instruction = ld_instr; RegWrite = 1; MemToReg = 1; dREN = 1; ALUResult = 32'h0000_1000; ihit = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) begin
                Instruction = enc(5'd1, 5'd1, 5'd9); RegDst = 1; MemToReg = 0; dREN = 0;
            end else begin
                ihit = 0;
            end
            n_cmp++; if (stall !== 1'b1 || pend_sel !== 5'd8 || WEN !== 1'b0) begin
                n_bad++; $display("FAIL load_wait%0d got stall=%0b pend=%0d wen=%0b want 1/8/0", i, stall, pend_sel, WEN);
            end
        end
        n_cmp++; if (lastInstruction !== ld_instr) begin
            n_bad++; $display("FAIL load_ignore_ihit got %h want %h", lastInstruction, ld_instr);
        end
        dhit = 1; dload = 32'hDEAD_BEEF;
        tick();
        dhit = 0;
        n_cmp++; if (WEN !== 1'b1 || wsel !== 5'd8 || wdat !== 32'hDEAD_BEEF || stall !== 1'b0 || pend_sel !== 5'd0) begin
            n_bad++; $display("FAIL load_commit got wen=%0b wsel=%0d wdat=%h stall=%0b pend=%0d want 1/8/deadbeef/0/0",
                              WEN, wsel, wdat, stall, pend_sel);
        end
        tick();
        n_cmp++; if (WEN !== 1'b0 || wdat !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL load_after got wen=%0b wdat=%h want 0/deadbeef", WEN, wdat);
        end
    endtask

    task automatic test_back_to_back();
        clr_ctrl();
        Instruction = {6'h23, 5'd0, 5'd4, 16'h0000}; RegWrite = 1; MemToReg = 1; dREN = 1;
        dhit = 1; dload = 32'h1122_3344; ALUResult = 32'h0000_0ABC; ihit = 1;
        tick();
        n_cmp++; if (WEN !== 1'b1 || wsel !== 5'd4 || wdat !== 32'h1122_3344 || stall !== 1'b0) begin
            n_bad++; $display("FAIL b2b_load got wen=%0b wsel=%0d wdat=%h stall=%0b want 1/4/11223344/0", WEN, wsel, wdat, stall);
        end
        dhit = 0; MemToReg = 0; dREN = 0; RegDst = 1;
        Instruction = enc(5'd3, 5'd3, 5'd1); ALUResult = 32'h0000_0001;
        tick();
        n_cmp++; if (WEN !== 1'b1 || wsel !== 5'd1 || wdat !== 32'h1) begin
            n_bad++; $display("FAIL b2b_r1 got wen=%0b wsel=%0d wdat=%h want 1/1/00000001", WEN, wsel, wdat);
        end
        Instruction = enc(5'd3, 5'd3, 5'd2); ALUResult = 32'h0000_0002;
        tick();
        ihit = 0;
        n_cmp++; if (WEN !== 1'b1 || wsel !== 5'd2 || wdat !== 32'h2) begin
            n_bad++; $display("FAIL b2b_r2 got wen=%0b wsel=%0d wdat=%h want 1/2/00000002", WEN, wsel, wdat);
        end
        tick();
        n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL b2b_end got wen=%0b want 0", WEN); end
    endtask

    task automatic test_reset_in_wait();
        clr_ctrl();
        Instruction = {6'h23, 5'd0, 5'd7, 16'h0004}; RegWrite = 1; MemToReg = 1; dREN = 1; ihit = 1;
        tick();
        ihit = 0;
        n_cmp++; if (stall !== 1'b1 || pend_sel !== 5'd7) begin
            n_bad++; $display("FAIL rstwait_pre got stall=%0b pend=%0d want 1/7", stall, pend_sel);
        end
        #1 nRST = 0;
        #1;
        n_cmp++; if (stall !== 1'b0 || pend_sel !== 5'd0 || wdat !== 32'h0) begin
            n_bad++; $display("FAIL rstwait_async got stall=%0b pend=%0d wdat=%h want 0/0/0", stall, pend_sel, wdat);
        end
        @(negedge CLK);
        nRST = 1;
        dhit = 1; dload = 32'hCAFE_F00D;
        tick();
        dhit = 0;
        n_cmp++; if (WEN !== 1'b0 || wdat !== 32'h0 || stall !== 1'b0) begin
            n_bad++; $display("FAIL rstwait_nowrite got wen=%0b wdat=%h stall=%0b want 0/0/0", WEN, wdat, stall);
        end
        tick();
        n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL rstwait_after got wen=%0b want 0", WEN); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_jal();
        test_load_late();
        test_back_to_back();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regfile_writeback

`default_nettype wire
